// File: rtl/vga_pkg.sv
// Shared VGA timing description, the standard 640x480@60 timing set and the
// colour-depth expansion helper used by the pixel output stage.
package vga_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 32'd640, h_fp: 32'd16, h_sync: 32'd96, h_bp: 32'd48,
    v_active: 32'd480, v_fp: 32'd10, v_sync: 32'd2,  v_bp: 32'd33
  };

  // MSB-first bit replication: the input pattern is repeated from the top down
  // so full-scale and zero inputs map to full-scale and zero outputs.
  function automatic logic [31:0] expand_color(input logic [31:0] value,
                                               input int in_w,
                                               input int out_w);
    logic [31:0] res;
    res = 32'd0;
    for (int k = 0; k < 32; k++) begin
      if (k < out_w) begin
        res[out_w - 1 - k] = value[in_w - 1 - (k % in_w)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with synchronous reset to a fixed value;
// DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
  input  logic         vgaclk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
  end else begin : g_shift
    logic [W-1:0] stage_r [DEPTH];

    // Shift one stage per enabled cycle; reset loads every stage with RST_VAL.
    always_ff @(posedge vgaclk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= RST_VAL;
        end
      end else if (en) begin
        stage_r[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end
    end

    assign dout = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster generator whose sync/DE/colour outputs are delayed
// to line up with a pixel source that has PIPE enabled cycles of latency.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_640X480_60.h_active,
  parameter int   H_FP     = VGA_640X480_60.h_fp,
  parameter int   H_SYNC   = VGA_640X480_60.h_sync,
  parameter int   H_BP     = VGA_640X480_60.h_bp,
  parameter int   V_ACTIVE = VGA_640X480_60.v_active,
  parameter int   V_FP     = VGA_640X480_60.v_fp,
  parameter int   V_SYNC   = VGA_640X480_60.v_sync,
  parameter int   V_BP     = VGA_640X480_60.v_bp,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10,
  parameter int   IN_R_W   = 3,
  parameter int   IN_G_W   = 3,
  parameter int   IN_B_W   = 2,
  parameter int   OUT_W    = 4,
  parameter int   PIPE     = 1
) (
  input  logic              vgaclk,
  input  logic              rst,
  input  logic              en,
  input  logic [IN_R_W-1:0] input_red,
  input  logic [IN_G_W-1:0] input_green,
  input  logic [IN_B_W-1:0] input_blue,
  output logic [CW-1:0]     hc_out,
  output logic [CW-1:0]     vc_out,
  output logic              fetch_active,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line_start,
  output logic              frame_start,
  output logic [OUT_W-1:0]  red,
  output logic [OUT_W-1:0]  green,
  output logic [OUT_W-1:0]  blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  // Flag bundle layout: {hs, vs, de, line_start, frame_start}
  localparam int           FW        = 5;
  localparam logic [FW-1:0] FLAG_IDLE = {~HS_POL, ~VS_POL, 3'b000};

  if ((H_TOTAL - 1) >= (2 ** CW) || (V_TOTAL - 1) >= (2 ** CW)) begin : g_chk_cw
    $error("vga_timing_pipe: CW too small for H_TOTAL/V_TOTAL");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
    $error("vga_timing_pipe: porch and sync widths must be at least 1");
  end
  if (PIPE < 0 || PIPE > 4) begin : g_chk_pipe
    $error("vga_timing_pipe: PIPE must be 0..4");
  end
  if (IN_R_W < 1 || IN_G_W < 1 || IN_B_W < 1 ||
      IN_R_W > OUT_W || IN_G_W > OUT_W || IN_B_W > OUT_W) begin : g_chk_cwidth
    $error("vga_timing_pipe: input colour widths must be 1..OUT_W");
  end

  logic [CW-1:0]    hc_r, vc_r;
  logic             fetch_s, hs_win_s, vs_win_s;
  logic [FW-1:0]    flags_s, flags_d_s;
  logic [OUT_W-1:0] red_x_s, green_x_s, blue_x_s;
  logic             hsync_r, vsync_r, de_r, line_start_r, frame_start_r;
  logic [OUT_W-1:0] red_r, green_r, blue_r;

  // Raster counters: column wraps every line, row wraps every frame.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hc_r <= ZERO_C;
      vc_r <= ZERO_C;
    end else if (en) begin
      if (hc_r == H_LAST) begin
        hc_r <= ZERO_C;
        vc_r <= (vc_r == V_LAST) ? ZERO_C : vc_r + CW'(1'b1);
      end else begin
        hc_r <= hc_r + CW'(1'b1);
      end
    end
  end

  assign fetch_s  = (hc_r < H_ACT_C) && (vc_r < V_ACT_C);
  assign hs_win_s = (hc_r >= HS_BEG) && (hc_r < HS_END);
  assign vs_win_s = (vc_r >= VS_BEG) && (vc_r < VS_END);
  assign flags_s  = {hs_win_s ? HS_POL : ~HS_POL,
                     vs_win_s ? VS_POL : ~VS_POL,
                     fetch_s,
                     hc_r == ZERO_C,
                     (hc_r == ZERO_C) && (vc_r == ZERO_C)};

  vga_delay_line #(
    .W      (FW),
    .DEPTH  (PIPE),
    .RST_VAL(FLAG_IDLE)
  ) u_flag_dly (
    .vgaclk(vgaclk),
    .rst   (rst),
    .en    (en),
    .din   (flags_s),
    .dout  (flags_d_s)
  );

  assign red_x_s   = OUT_W'(expand_color(32'(input_red),   IN_R_W, OUT_W));
  assign green_x_s = OUT_W'(expand_color(32'(input_green), IN_G_W, OUT_W));
  assign blue_x_s  = OUT_W'(expand_color(32'(input_blue),  IN_B_W, OUT_W));

  // Output stage: colour is captured together with the flags it belongs to,
  // and forced to black outside the active area.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hsync_r       <= ~HS_POL;
      vsync_r       <= ~VS_POL;
      de_r          <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      red_r         <= {OUT_W{1'b0}};
      green_r       <= {OUT_W{1'b0}};
      blue_r        <= {OUT_W{1'b0}};
    end else if (en) begin
      hsync_r       <= flags_d_s[4];
      vsync_r       <= flags_d_s[3];
      de_r          <= flags_d_s[2];
      line_start_r  <= flags_d_s[1];
      frame_start_r <= flags_d_s[0];
      red_r         <= flags_d_s[2] ? red_x_s   : {OUT_W{1'b0}};
      green_r       <= flags_d_s[2] ? green_x_s : {OUT_W{1'b0}};
      blue_r        <= flags_d_s[2] ? blue_x_s  : {OUT_W{1'b0}};
    end
  end

  assign hc_out       = hc_r;
  assign vc_out       = vc_r;
  assign fetch_active = fetch_s;
  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign de           = de_r;
  assign line_start   = line_start_r;
  assign frame_start  = frame_start_r;
  assign red          = red_r;
  assign green        = green_r;
  assign blue         = blue_r;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Scoreboard bench: four DUT configurations share clock/rst/en; expected output
// records are queued per enabled-cycle index and checked by per-DUT monitors.
module tb_vga_timing_pipe;

  localparam int NDUT = 4;
  localparam int C_HA  [NDUT] = '{640, 640, 640, 8};
  localparam int C_HF  [NDUT] = '{16, 16, 16, 2};
  localparam int C_HS  [NDUT] = '{96, 96, 96, 3};
  localparam int C_HB  [NDUT] = '{48, 48, 48, 1};
  localparam int C_VA  [NDUT] = '{480, 480, 480, 4};
  localparam int C_VF  [NDUT] = '{10, 10, 10, 1};
  localparam int C_VS  [NDUT] = '{2, 2, 2, 1};
  localparam int C_VB  [NDUT] = '{33, 33, 33, 1};
  localparam int C_POL [NDUT] = '{0, 0, 0, 1};
  localparam int C_CW  [NDUT] = '{10, 10, 10, 4};
  localparam int C_P   [NDUT] = '{1, 0, 3, 4};

  typedef struct packed {
    int         hc;
    int         vc;
    int         oh;
    int         ov;
    logic       ovok;
    logic       fa;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] src_v [NDUT];
  int         k_cur = 0;
  int         k_nxt = 0;
  int         seg   = 0;
  int         mult  = 1;
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock counter used to time sync/pulse periods.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int h_tot(input int g);
    return C_HA[g] + C_HF[g] + C_HS[g] + C_HB[g];
  endfunction

  function automatic int v_tot(input int g);
    return C_VA[g] + C_VF[g] + C_VS[g] + C_VB[g];
  endfunction

  // Pixel source: a fixed colour in two column bands, otherwise a coordinate pattern.
  function automatic logic [7:0] src(input int h, input int v);
    logic [31:0] hb;
    logic [31:0] vb;
    hb = h;
    vb = v;
    if ((h >= 16 && h < 24) || (h >= 696 && h < 704)) return {3'b111, 3'b000, 2'b01};
    return {hb[2:0], hb[5:3], vb[1:0]};
  endfunction

  function automatic logic [7:0] src_at(input int k, input int g);
    if (k < 0) return 8'hFF;
    return src(k % h_tot(g), (k / h_tot(g)) % v_tot(g));
  endfunction

  // Expected outputs when the DUT holds state index k (enabled cycles since reset).
  function automatic rec_t exp_of(input int k, input int g);
    rec_t       e;
    int         ht, vt, kk, h, v;
    logic       pol;
    logic [7:0] c;
    ht  = h_tot(g);
    vt  = v_tot(g);
    pol = (C_POL[g] != 0);
    e   = '0;
    e.hc = k % ht;
    e.vc = (k / ht) % vt;
    e.fa = (e.hc < C_HA[g]) && (e.vc < C_VA[g]);
    e.hs = ~pol;
    e.vs = ~pol;
    if (k >= C_P[g] + 1) begin
      kk = k - C_P[g] - 1;
      h  = kk % ht;
      v  = (kk / ht) % vt;
      e.ovok = 1'b1;
      e.oh = h;
      e.ov = v;
      e.hs = (h >= C_HA[g] + C_HF[g] && h < C_HA[g] + C_HF[g] + C_HS[g]) ? pol : ~pol;
      e.vs = (v >= C_VA[g] + C_VF[g] && v < C_VA[g] + C_VF[g] + C_VS[g]) ? pol : ~pol;
      e.de = (h < C_HA[g]) && (v < C_VA[g]);
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
      if (e.de) begin
        c   = src(h, v);
        e.r = {c[7:5], c[7]};
        e.g = {c[4:2], c[4]};
        e.b = {c[1:0], c[1:0]};
      end
    end
    return e;
  endfunction

  task automatic chk(input logic ok, input string name, input int g, input int got, input int want);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0d, want %0d", name, g, cyc, got, want);
    end
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int CWG = C_CW[gi];
    logic [CWG-1:0] hc_s, vc_s;
    logic           fa_s, hs_s, vs_s, de_s, ls_s, fs_s;
    logic [3:0]     r_s, g_s, b_s;
    rec_t           q [$];

    vga_timing_pipe #(
      .H_ACTIVE(C_HA[gi]), .H_FP(C_HF[gi]), .H_SYNC(C_HS[gi]), .H_BP(C_HB[gi]),
      .V_ACTIVE(C_VA[gi]), .V_FP(C_VF[gi]), .V_SYNC(C_VS[gi]), .V_BP(C_VB[gi]),
      .HS_POL(C_POL[gi] != 0), .VS_POL(C_POL[gi] != 0), .CW(CWG),
      .IN_R_W(3), .IN_G_W(3), .IN_B_W(2), .OUT_W(4), .PIPE(C_P[gi])
    ) u_dut (
      .vgaclk      (clk),
      .rst         (rst),
      .en          (en),
      .input_red   (src_v[gi][7:5]),
      .input_green (src_v[gi][4:2]),
      .input_blue  (src_v[gi][1:0]),
      .hc_out      (hc_s),
      .vc_out      (vc_s),
      .fetch_active(fa_s),
      .hsync       (hs_s),
      .vsync       (vs_s),
      .de          (de_s),
      .line_start  (ls_s),
      .frame_start (fs_s),
      .red         (r_s),
      .green       (g_s),
      .blue        (b_s)
    );

    // Scoreboard producer: one expected record per clock edge.
    always @(posedge clk) q.push_back(exp_of(k_nxt, gi));

    // Monitor: pop and compare after every edge, plus hand-valued spot checks.
    initial begin : mon
      rec_t e;
      rec_t a;
      logic ls_q, fs_q;
      int   ls_c, fs_c, ls_sg, fs_sg, ht, vt;
      ls_q = 1'b0; fs_q = 1'b0;
      ls_c = 0; fs_c = 0; ls_sg = -1; fs_sg = -1;
      ht = h_tot(gi);
      vt = v_tot(gi);
      forever begin
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
          chk(1'b0, "queue_underflow", gi, 0, 1);
        end else begin
          e = q.pop_front();
          a = e;
          a.hc = int'(hc_s); a.vc = int'(vc_s);
          a.fa = fa_s; a.hs = hs_s; a.vs = vs_s; a.de = de_s; a.ls = ls_s; a.fs = fs_s;
          a.r = r_s; a.g = g_s; a.b = b_s;
          n_vec++;
          if (a != e) begin
            n_err++;
            $display("FAIL outputs dut%0d cycle %0d: got hc=%0d vc=%0d fa=%b hs=%b vs=%b de=%b ls=%b fs=%b rgb=%h%h%h, want hc=%0d vc=%0d fa=%b hs=%b vs=%b de=%b ls=%b fs=%b rgb=%h%h%h",
                     gi, cyc, a.hc, a.vc, a.fa, a.hs, a.vs, a.de, a.ls, a.fs, a.r, a.g, a.b,
                     e.hc, e.vc, e.fa, e.hs, e.vs, e.de, e.ls, e.fs, e.r, e.g, e.b);
          end
          if (C_HA[gi] == 640 && e.ovok && e.ov == 0 && e.oh == 5)
            chk(r_s == 4'b1011, "red_at_h5", gi, int'(r_s), 11);
          if (C_HA[gi] == 640 && e.ovok && e.ov < 480 && e.oh == 20)
            chk({r_s, g_s, b_s} == 12'hF05, "expand_active", gi, int'({r_s, g_s, b_s}), 12'hF05);
          if (C_HA[gi] == 640 && e.ovok && e.ov < 480 && e.oh == 700)
            chk({r_s, g_s, b_s} == 12'h000, "blank_h700", gi, int'({r_s, g_s, b_s}), 0);
          if (C_HA[gi] == 640 && e.ovok && e.ov < 480 && e.oh == 639)
            chk(de_s == 1'b1, "de_last_active", gi, int'(de_s), 1);
          if (C_HA[gi] == 640 && e.ovok && e.ov < 480 && e.oh == 640)
            chk(de_s == 1'b0, "de_fall_h640", gi, int'(de_s), 0);
          if (C_HA[gi] == 640 && e.ovok && e.oh >= 656 && e.oh <= 751)
            chk(hs_s == 1'b0, "hsync_low_window", gi, int'(hs_s), 0);
          if (C_POL[gi] == 1 && e.ovok && e.oh >= 10 && e.oh <= 12)
            chk(hs_s == 1'b1, "small_hsync_high", gi, int'(hs_s), 1);
          if (C_POL[gi] == 1 && e.ovok && e.oh == 13)
            chk(hs_s == 1'b0, "small_hsync_end", gi, int'(hs_s), 0);
          if (C_POL[gi] == 1 && e.ovok && e.ov == 5)
            chk(vs_s == 1'b1, "small_vsync_high", gi, int'(vs_s), 1);
          if (ls_s && !ls_q) begin
            if (ls_sg == seg) chk(cyc - ls_c == ht * mult, "line_period", gi, cyc - ls_c, ht * mult);
            ls_sg = seg;
            ls_c  = cyc;
          end
          if (fs_s && !fs_q) begin
            if (fs_sg == seg) chk(cyc - fs_c == ht * vt * mult, "frame_period", gi, cyc - fs_c, ht * vt * mult);
            fs_sg = seg;
            fs_c  = cyc;
          end
          ls_q = ls_s;
          fs_q = fs_s;
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input int m);
    @(negedge clk);
    if (r || m != mult) seg++;
    mult  = m;
    rst   = r;
    en    = e;
    k_cur = k_nxt;
    k_nxt = r ? 0 : (e ? k_cur + 1 : k_cur);
    for (int g = 0; g < NDUT; g++) src_v[g] = src_at(k_cur - C_P[g], g);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int g = 0; g < NDUT; g++) src_v[g] = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 1);
    for (int i = 0; i < 6800; i++) step(1'b0, (i % 4) == 3, 4);
    for (int i = 0; i < 1000 && (k_nxt % 800) != 300; i++) step(1'b0, 1'b1, 1);
    step(1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 1);
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
